// File: rtl/feedback_scheduler_pkg.sv
// Shared vending definitions: scheduler FSM encoding, hold kinds and FIFO sizing.
package feedback_scheduler_pkg;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned ITEM_W     = 2;
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE_ERR  = 2'd1,
      ST_ISSUE_VEND = 2'd2,
      ST_HOLD       = 2'd3
   } state_e;

   typedef enum logic {
      HOLD_VEND = 1'b0,
      HOLD_ERR  = 1'b1
   } hold_kind_e;

endpackage

// File: rtl/feedback_scheduler_if.sv
// Request/status bundle between the vending controller and the feedback scheduler.
interface feedback_scheduler_if;
   import feedback_scheduler_pkg::*;

   logic              vend_req;
   logic [ITEM_W-1:0] vend_item;
   logic              coin_err_req;
   logic              stock_err_req;
   logic              clear_overflow;
   logic              vend_event;
   logic              error_event;
   logic [ITEM_W-1:0] item_select;
   logic              busy;
   logic [CNT_W-1:0]  vend_pending;
   logic              overflow;

   modport master (
      output vend_req, vend_item, coin_err_req, stock_err_req, clear_overflow,
      input  vend_event, error_event, item_select, busy, vend_pending, overflow
   );

   modport slave (
      input  vend_req, vend_item, coin_err_req, stock_err_req, clear_overflow,
      output vend_event, error_event, item_select, busy, vend_pending, overflow
   );

endinterface

// File: rtl/feedback_scheduler_item_fifo.sv
// Small queue of pending vend items; a push into a full queue is accepted only alongside a pop.
module item_fifo
   import feedback_scheduler_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ITEM_W-1:0] data_i,
   output logic [ITEM_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [ITEM_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Occupancy update for simultaneous push/pop
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers and count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/feedback_scheduler.sv
// Schedules vend/error animations to the LED block: errors preempt vend holds, vends queue in order.
module feedback_scheduler
   import feedback_scheduler_pkg::*;
#(
   parameter int unsigned TICK_BITS  = 24,
   parameter int unsigned VEND_HOLD  = 7,
   parameter int unsigned ERROR_HOLD = 9
) (
   input logic           clk,
   input logic           rst,
   feedback_scheduler_if.slave bus
);

   localparam int unsigned HOLD_MAX = (VEND_HOLD > ERROR_HOLD) ? VEND_HOLD : ERROR_HOLD;
   localparam int unsigned HOLD_W   = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

   state_e              state_q, state_d;
   hold_kind_e          kind_q, kind_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [TICK_BITS-1:0] tick_cnt_q;
   logic                tick_c;
   logic                err_pending_q, err_pending_d;
   logic                overflow_q, overflow_d;
   logic                vend_event_q, vend_event_d;
   logic                error_event_q, error_event_d;
   logic                busy_q, busy_d;
   logic [ITEM_W-1:0]   item_select_q, item_select_d;

   logic                fifo_push, fifo_pop, fifo_full, fifo_empty, drop_c, new_err_c;
   logic [ITEM_W-1:0]   fifo_head;
   logic [CNT_W-1:0]    fifo_count;

   item_fifo u_item_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (bus.vend_item),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign tick_c    = (tick_cnt_q == '0);
   assign new_err_c = bus.coin_err_req || bus.stock_err_req;
   assign fifo_push = bus.vend_req && (!fifo_full || fifo_pop);
   assign drop_c    = bus.vend_req && fifo_full && !fifo_pop;

   // Sticky flags: errors coalesce into one pending issue; a drop beats a clear
   always_comb begin
      err_pending_d = new_err_c || (err_pending_q && (state_q != ST_ISSUE_ERR));
      overflow_d    = overflow_q;
      if (drop_c)                  overflow_d = 1'b1;
      else if (bus.clear_overflow) overflow_d = 1'b0;
   end

   // Next-state, hold countdown and registered-output staging
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      kind_d   = kind_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (err_pending_q) begin
               state_d = ST_ISSUE_ERR;
            end else if (!fifo_empty) begin
               state_d  = ST_ISSUE_VEND;
               fifo_pop = 1'b1;
            end
         end
         ST_ISSUE_ERR: begin
            hold_d  = HOLD_W'(ERROR_HOLD);
            kind_d  = HOLD_ERR;
            state_d = ST_HOLD;
         end
         ST_ISSUE_VEND: begin
            hold_d  = HOLD_W'(VEND_HOLD);
            kind_d  = HOLD_VEND;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if ((kind_q == HOLD_VEND) && err_pending_q) begin
               state_d = ST_ISSUE_ERR;
            end else if (tick_c) begin
               if (hold_q == '0) state_d = ST_IDLE;
               else              hold_d  = hold_q - HOLD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      vend_event_d  = (state_d == ST_ISSUE_VEND);
      error_event_d = (state_d == ST_ISSUE_ERR);
      busy_d        = (state_d != ST_IDLE);
      item_select_d = fifo_pop ? fifo_head : item_select_q;
   end

   // State, prescaler and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         kind_q        <= HOLD_VEND;
         hold_q        <= '0;
         tick_cnt_q    <= '0;
         err_pending_q <= 1'b0;
         overflow_q    <= 1'b0;
         vend_event_q  <= 1'b0;
         error_event_q <= 1'b0;
         busy_q        <= 1'b0;
         item_select_q <= '0;
      end else begin
         state_q       <= state_d;
         kind_q        <= kind_d;
         hold_q        <= hold_d;
         tick_cnt_q    <= tick_cnt_q + TICK_BITS'(1);
         err_pending_q <= err_pending_d;
         overflow_q    <= overflow_d;
         vend_event_q  <= vend_event_d;
         error_event_q <= error_event_d;
         busy_q        <= busy_d;
         item_select_q <= item_select_d;
      end
   end

   assign bus.vend_event   = vend_event_q;
   assign bus.error_event  = error_event_q;
   assign bus.item_select  = item_select_q;
   assign bus.busy         = busy_q;
   assign bus.vend_pending = fifo_count;
   assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_feedback_scheduler.sv
// Directed bench for feedback_scheduler with an event scoreboard.
module tb_feedback_scheduler;

   localparam int VH = 7;
   localparam int EH = 9;
   localparam int TP = 8;   // tick period for TICK_BITS=3

   typedef struct packed {
      logic       is_err;
      logic [1:0] item;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   n;

   feedback_scheduler_if bus ();

   feedback_scheduler #(.TICK_BITS(3), .VEND_HOLD(VH), .ERROR_HOLD(EH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int k);
      repeat (k) cycle();
   endtask

   task automatic wait_vend(input int bound, output int cnt);
      cnt = 0;
      while (!bus.vend_event && cnt < bound) begin
         cycle();
         cnt++;
      end
      chk("vend_wait_timeout", int'(bus.vend_event), 1);
   endtask

   task automatic wait_idle(input int bound, output int cnt);
      cnt = 0;
      while (bus.busy && cnt < bound) begin
         cnt++;
         cycle();
      end
      chk("idle_wait_timeout", int'(bus.busy), 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_vend_event"},   int'(bus.vend_event), 0);
      chk({tag, "_error_event"},  int'(bus.error_event), 0);
      chk({tag, "_item_select"},  int'(bus.item_select), 0);
      chk({tag, "_busy"},         int'(bus.busy), 0);
      chk({tag, "_vend_pending"}, int'(bus.vend_pending), 0);
      chk({tag, "_overflow"},     int'(bus.overflow), 0);
   endtask

   // Scoreboard: every event pulse must match the oldest expected event
   always @(negedge clk) begin
      if (!rst && (bus.vend_event || bus.error_event)) begin
         chk("event_mutex", int'(bus.vend_event & bus.error_event), 0);
         chk("event_expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("event_kind", int'(bus.error_event), int'(mon_e.is_err));
            if (!mon_e.is_err) chk("event_item", int'(bus.item_select), int'(mon_e.item));
         end
      end
   end

   initial begin
      rst                = 1'b1;
      bus.vend_req       = 1'b0;
      bus.vend_item      = 2'd0;
      bus.coin_err_req   = 1'b0;
      bus.stock_err_req  = 1'b0;
      bus.clear_overflow = 1'b0;
      cycles(3);
      check_all_zero("reset");
      rst = 1'b0;
      cycles(2);

      // Single vend from idle: 2-cycle latency, hold of VH+1 ticks
      bus.vend_req = 1'b1; bus.vend_item = 2'd2;
      exp_q.push_back(exp_t'{is_err: 1'b0, item: 2'd2});
      cycle();
      bus.vend_req = 1'b0;
      chk("s1_no_early_vend", int'(bus.vend_event), 0);
      chk("s1_pending_1", int'(bus.vend_pending), 1);
      cycle();
      chk("s1_vend_event", int'(bus.vend_event), 1);
      chk("s1_item", int'(bus.item_select), 2);
      chk("s1_busy", int'(bus.busy), 1);
      wait_idle(200, n);
      chk("s1_hold_window", int'(n >= VH*TP + 2 && n <= VH*TP + 9), 1);
      chk("s1_item_stable", int'(bus.item_select), 2);

      // Error and vend together: error first, vend after the error hold
      bus.coin_err_req = 1'b1; bus.vend_req = 1'b1; bus.vend_item = 2'd1;
      exp_q.push_back(exp_t'{is_err: 1'b1, item: 2'd0});
      exp_q.push_back(exp_t'{is_err: 1'b0, item: 2'd1});
      cycle();
      bus.coin_err_req = 1'b0; bus.vend_req = 1'b0;
      cycle();
      chk("s2_error_first", int'(bus.error_event), 1);
      chk("s2_no_vend", int'(bus.vend_event), 0);
      chk("s2_pending", int'(bus.vend_pending), 1);
      wait_vend(300, n);
      chk("s2_vend_after_hold", int'(n > EH*TP), 1);
      chk("s2_item1", int'(bus.item_select), 1);
      wait_idle(200, n);

      // Error during a vend hold preempts it
      bus.vend_req = 1'b1; bus.vend_item = 2'd0;
      exp_q.push_back(exp_t'{is_err: 1'b0, item: 2'd0});
      cycle();
      bus.vend_req = 1'b0;
      cycle();
      chk("s3_vend", int'(bus.vend_event), 1);
      cycles(4);
      bus.stock_err_req = 1'b1;
      exp_q.push_back(exp_t'{is_err: 1'b1, item: 2'd0});
      cycle();
      bus.stock_err_req = 1'b0;
      chk("s3_no_err_yet", int'(bus.error_event), 0);
      cycle();
      chk("s3_err_preempt", int'(bus.error_event), 1);
      chk("s3_busy", int'(bus.busy), 1);
      wait_idle(200, n);

      // Saturation and overflow while busy
      bus.vend_req = 1'b1; bus.vend_item = 2'd3;
      exp_q.push_back(exp_t'{is_err: 1'b0, item: 2'd3});
      cycle();
      bus.vend_req = 1'b0;
      cycle();
      chk("s4_first_vend", int'(bus.vend_event), 1);
      for (int i = 0; i < 6; i++) begin
         bus.vend_req  = 1'b1;
         bus.vend_item = 2'(i % 4);
         if (i < 4) exp_q.push_back(exp_t'{is_err: 1'b0, item: 2'(i % 4)});
         cycle();
         if (i == 3) begin
            chk("s4_full_pending", int'(bus.vend_pending), 4);
            chk("s4_no_ovf_yet", int'(bus.overflow), 0);
         end
      end
      bus.vend_req = 1'b0;
      chk("s4_overflow", int'(bus.overflow), 1);
      chk("s4_pending_sat", int'(bus.vend_pending), 4);
      bus.vend_req = 1'b1; bus.vend_item = 2'd2; bus.clear_overflow = 1'b1;
      cycle();
      bus.vend_req = 1'b0; bus.clear_overflow = 1'b0;
      chk("s4_drop_wins", int'(bus.overflow), 1);
      bus.clear_overflow = 1'b1;
      cycle();
      bus.clear_overflow = 1'b0;
      chk("s4_cleared", int'(bus.overflow), 0);
      chk("s4_pending_kept", int'(bus.vend_pending), 4);
      n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin
         cycle();
         n++;
      end
      chk("s4_drain", exp_q.size(), 0);
      chk("s4_idle", int'(bus.busy), 0);
      chk("s4_empty", int'(bus.vend_pending), 0);

      // Reset mid-hold with queued items discards everything
      bus.vend_req = 1'b1; bus.vend_item = 2'd0;
      exp_q.push_back(exp_t'{is_err: 1'b0, item: 2'd0});
      cycle();
      bus.vend_req = 1'b0;
      cycle();
      chk("s5_vend", int'(bus.vend_event), 1);
      for (int i = 1; i < 4; i++) begin
         bus.vend_req  = 1'b1;
         bus.vend_item = 2'(i);
         cycle();
      end
      bus.vend_req = 1'b0;
      cycles(2);
      chk("s5_pending_3", int'(bus.vend_pending), 3);
      chk("s5_busy", int'(bus.busy), 1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("s5_async_reset");
      cycles(2);
      rst = 1'b0;
      cycles(200);
      check_all_zero("s5_after_release");
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/feedback_scheduler.md
FEEDBACK_SCHEDULER -- requirements
Module: feedback_scheduler

Interface
REQ-001 Parameter TICK_BITS, default 24: width of the free-running slow-tick prescaler.
REQ-002 Parameter VEND_HOLD, default 7: slow ticks the LED block is held busy after a vend issue.
REQ-003 Parameter ERROR_HOLD, default 9: slow ticks the LED block is held busy after an error issue.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 vend_req  input  1  one-cycle request to play a vend animation.
REQ-007 vend_item  input  2  item index accompanying vend_req.
REQ-008 coin_err_req  input  1  one-cycle coin-path error request.
REQ-009 stock_err_req  input  1  one-cycle sold-out error request.
REQ-010 clear_overflow  input  1  clears the overflow flag.
REQ-011 vend_event  output  1  registered one-cycle pulse to the LED feedback block.
REQ-012 error_event  output  1  registered one-cycle pulse to the LED feedback block.
REQ-013 item_select  output  2  item of the most recent vend issue.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 vend_pending  output  3  vend FIFO occupancy, 0..4.
REQ-016 overflow  output  1  sticky flag: a vend request was dropped.

Function
REQ-017 Vend requests SHALL enter a 4-entry FIFO of 2-bit items; push on vend_req when not full, or when full and popped in the same cycle.
REQ-018 vend_req while full with no same-cycle pop SHALL be dropped and SHALL set overflow the next cycle.
REQ-019 clear_overflow SHALL clear overflow; a simultaneous drop SHALL win (overflow stays 1).
REQ-020 coin_err_req or stock_err_req SHALL set a single err_pending flag; repeated errors before issue coalesce into one.
REQ-021 Prescaler: TICK_BITS counter, free-running from reset; tick is high while the counter equals 0.
REQ-022 FSM states: IDLE, ISSUE_ERR, ISSUE_VEND, HOLD.
REQ-023 IDLE -> ISSUE_ERR if err_pending; else IDLE -> ISSUE_VEND if FIFO non-empty; else stay. Errors have strict priority.
REQ-024 ISSUE_ERR: lasts one cycle; error_event=1; clear err_pending unless a new error arrives that cycle; load hold counter = ERROR_HOLD; -> HOLD.
REQ-025 ISSUE_VEND: lasts one cycle; vend_event=1; pop FIFO head into item_select; load hold counter = VEND_HOLD; mark hold kind vend; -> HOLD.
REQ-026 item_select SHALL be valid in the same cycle as vend_event and stay stable until the next ISSUE_VEND.
REQ-027 HOLD: on each tick, decrement hold counter; a tick with counter 0 returns the FSM to IDLE.
REQ-028 In HOLD of kind vend, err_pending SHALL preempt: -> ISSUE_ERR next cycle, discarding the remaining vend hold.
REQ-029 In HOLD of kind error, new errors SHALL only pend; no re-issue until return to IDLE.
REQ-030 Latency from an idle request edge to its event pulse SHALL be exactly 2 cycles.
REQ-031 vend_event and error_event SHALL never be high in the same cycle.

Reset
REQ-032 rst SHALL asynchronously force state IDLE, FIFO empty, err_pending 0, hold counter 0, prescaler 0.
REQ-033 Reset outputs: vend_event 0, error_event 0, item_select 0, busy 0, vend_pending 0, overflow 0.
REQ-034 Reset asserted mid-HOLD or mid-ISSUE SHALL discard all pending work; no pulse is emitted after release until a new request.

Structure
REQ-035 FSM state encodings and the FIFO depth constant (4) SHALL live in the shared vending package.
REQ-036 The FIFO SHALL be one sub-module, item_fifo (depth 4, width 2, with push, pop, full, empty, count).

Verification
REQ-037 TICK_BITS=3 for all scenarios.
REQ-038 Idle, vend_req item 2 -> vend_event 2 cycles later, item_select=2, busy until VEND_HOLD+1 ticks pass.
REQ-039 coin_err_req and vend_req (item 1) in the same cycle -> error_event first; vend_event item 1 only after the error hold ends.
REQ-040 vend item 0 issued, then stock_err_req during HOLD -> error_event within 2 cycles, before the hold expires.
REQ-041 Six back-to-back vend_req while busy -> vend_pending saturates at 4, overflow=1, four vends issued in order; clear_overflow -> 0.
REQ-042 Assert rst during HOLD with 3 items queued -> all outputs 0; no events after release without new requests.
